// File: rtl/dht11_pkg.sv
// Shared types and helpers for the DHT11 sample scheduler.
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        GAP,
        PUBLISH
    } sched_state_t;

    typedef struct packed {
        logic [7:0] temp;
        logic [7:0] hum;
    } dht11_reading_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dht11_tick_timer.sv
// Cycle counter: saturates at N (hit while saturated) or wraps
// every N cycles (hit on the last count of each period).
module dht11_tick_timer #(
    parameter int unsigned N        = 100,
    parameter bit          PERIODIC = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned W = $clog2(N + 1);
    localparam logic [W-1:0] LAST = PERIODIC ? W'(N - 1) : W'(N);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count != LAST) begin
                count <= count + 1'b1;
            end else if (PERIODIC) begin
                count <= '0;
            end
        end
    end

    assign hit = (count == LAST);

endmodule

// File: rtl/dht11_sample_scheduler.sv
// Decides when a DHT11 access may start, retries failed reads and
// publishes results (or the cached last good reading) to the host.
module dht11_sample_scheduler #(
    parameter int unsigned MIN_GAP_CYCLES     = 100_000_000,
    parameter int unsigned AUTO_PERIOD_CYCLES = 200_000_000,
    parameter int unsigned TIMEOUT_CYCLES     = 30_000_000,
    parameter int unsigned MAX_RETRIES        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        auto_en,
    input  logic        host_req,
    output logic        host_ack,
    output logic        rd_start,
    input  logic        rd_busy,
    input  logic        rd_done,
    input  logic        rd_ok,
    input  logic [15:0] rd_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_err,
    output logic [15:0] last_good,
    output logic        stale,
    output logic [7:0]  err_count
);

    import dht11_pkg::*;

    localparam int unsigned RW =
        (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);

    sched_state_t   state;
    dht11_reading_t sample;
    logic [RW-1:0]  retry;
    logic host_pend;
    logic auto_pend;
    logic cap_host;
    logic gap_ok;
    logic auto_hit;
    logic auto_tick;
    logic timed_out;
    logic access_end;
    logic capture;

    assign sample     = rd_data;
    assign auto_tick  = auto_en & auto_hit;
    assign access_end = (state == WAIT) & (rd_done | timed_out);
    assign capture    = (state == IDLE) & (host_pend | auto_pend) & gap_ok;

    dht11_tick_timer #(
        .N(MIN_GAP_CYCLES)
    ) u_gap (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (access_end),
        .en   (1'b1),
        .hit  (gap_ok)
    );

    dht11_tick_timer #(
        .N       (AUTO_PERIOD_CYCLES),
        .PERIODIC(1'b1)
    ) u_auto (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!auto_en),
        .en   (auto_en),
        .hit  (auto_hit)
    );

    dht11_tick_timer #(
        .N(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state != WAIT),
        .en   (1'b1),
        .hit  (timed_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            retry     <= '0;
            host_pend <= 1'b0;
            auto_pend <= 1'b0;
            cap_host  <= 1'b0;
            host_ack  <= 1'b0;
            rd_start  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            last_good <= '0;
            stale     <= 1'b1;
            err_count <= '0;
        end else begin
            rd_start <= 1'b0;
            host_ack <= 1'b0;

            // On capture the pendings move into the sample; only
            // requests arriving from now on remain pending.
            if (capture) begin
                host_pend <= host_req;
                auto_pend <= auto_tick;
            end else begin
                host_pend <= host_pend | host_req;
                auto_pend <= auto_en & (auto_pend | auto_tick);
            end

            unique case (state)
                IDLE: begin
                    if (capture) begin
                        cap_host <= host_pend;
                        if (!rd_busy) begin
                            rd_start <= 1'b1;
                            state    <= WAIT;
                        end else begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    if (!rd_busy) begin
                        rd_start <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (rd_done && rd_ok) begin
                        res_data  <= sample;
                        last_good <= sample;
                        res_err   <= 1'b0;
                        stale     <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= PUBLISH;
                    end else if (rd_done || timed_out) begin
                        err_count <= sat_inc8(err_count);
                        if (retry < RMAX) begin
                            retry <= retry + 1'b1;
                            state <= GAP;
                        end else begin
                            res_data  <= last_good;
                            res_err   <= 1'b1;
                            stale     <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= PUBLISH;
                        end
                    end
                end
                GAP: begin
                    if (gap_ok) begin
                        if (!rd_busy) begin
                            rd_start <= 1'b1;
                            state    <= WAIT;
                        end else begin
                            state <= START;
                        end
                    end
                end
                PUBLISH: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        host_ack  <= cap_host;
                        cap_host  <= 1'b0;
                        retry     <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_sample_scheduler.sv
// Bench for dht11_sample_scheduler: timestamp-based reference model
// compared every cycle, plus directed scenarios with literal checks.
module tb_dht11_sample_scheduler;

    localparam int MIN_GAP = 100;
    localparam int AUTO_P  = 500;
    localparam int TMO     = 50;
    localparam int MAXR    = 2;

    localparam int PH_IDLE   = 0;
    localparam int PH_LAUNCH = 1;
    localparam int PH_READ   = 2;
    localparam int PH_PUB    = 3;

    logic        clk;
    logic        rst_n;
    logic        auto_en;
    logic        host_req;
    logic        host_ack;
    logic        rd_start;
    logic        rd_busy;
    logic        rd_done;
    logic        rd_ok;
    logic [15:0] rd_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;
    logic [15:0] last_good;
    logic        stale;
    logic [7:0]  err_count;

    int n_chk;
    int n_fail;
    int ack_cnt;

    dht11_sample_scheduler #(
        .MIN_GAP_CYCLES    (MIN_GAP),
        .AUTO_PERIOD_CYCLES(AUTO_P),
        .TIMEOUT_CYCLES    (TMO),
        .MAX_RETRIES       (MAXR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .auto_en  (auto_en),
        .host_req (host_req),
        .host_ack (host_ack),
        .rd_start (rd_start),
        .rd_busy  (rd_busy),
        .rd_done  (rd_done),
        .rd_ok    (rd_ok),
        .rd_data  (rd_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_err  (res_err),
        .last_good(last_good),
        .stale    (stale),
        .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model in terms of timestamps: cyc counts clock edges
    // since reset release; m_end is the edge at which the last access
    // ended; t0 is the edge that issued the current rd_start.
    int          cyc, m_end, t0, fails, ph, p0, a_run;
    bit          hp, ap, cap, m_gap, m_tick, m_capt;
    bit          e_start, e_valid, e_err, e_stale, e_ack;
    logic [15:0] e_data, e_last;
    int          e_errc;

    task model_step();
        if (!rst_n) begin
            cyc = 0; m_end = 0; t0 = 0; fails = 0; ph = PH_IDLE;
            a_run = 0; hp = 0; ap = 0; cap = 0;
            e_start = 0; e_valid = 0; e_err = 0; e_stale = 1;
            e_ack = 0; e_data = '0; e_last = '0; e_errc = 0;
        end else begin
            cyc++;
            p0 = ph;
            m_gap = (cyc - 1 - m_end) >= MIN_GAP;
            a_run = auto_en ? a_run + 1 : 0;
            m_tick = auto_en && (a_run % AUTO_P == 0);
            e_start = 0;
            e_ack = 0;
            m_capt = (p0 == PH_IDLE) && (hp || ap) && m_gap;
            if (m_capt) begin
                cap = hp; hp = host_req; ap = m_tick; ph = PH_LAUNCH;
            end else begin
                hp = hp || host_req; ap = ap || m_tick;
            end
            if (!auto_en) ap = 0;
            if ((p0 == PH_LAUNCH || m_capt) && m_gap && !rd_busy) begin
                e_start = 1; t0 = cyc; ph = PH_READ;
            end
            if (p0 == PH_READ) begin
                if (rd_done && rd_ok) begin
                    m_end = cyc; e_data = rd_data; e_last = rd_data;
                    e_err = 0; e_stale = 0; e_valid = 1; ph = PH_PUB;
                end else if (rd_done || (cyc - 1 - t0) >= TMO) begin
                    m_end = cyc;
                    if (e_errc < 255) e_errc++;
                    if (fails < MAXR) begin
                        fails++; ph = PH_LAUNCH;
                    end else begin
                        e_data = e_last; e_err = 1; e_stale = 1;
                        e_valid = 1; ph = PH_PUB;
                    end
                end
            end
            if (p0 == PH_PUB && res_ready) begin
                e_valid = 0; e_ack = cap; cap = 0; fails = 0;
                ph = PH_IDLE;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    always @(negedge clk) begin
        chk("rd_start", rd_start, e_start);
        chk("res_valid", res_valid, e_valid);
        chk("res_data", res_data, e_data);
        chk("res_err", res_err, e_err);
        chk("last_good", last_good, e_last);
        chk("stale", stale, e_stale);
        chk("err_count", err_count, e_errc);
        chk("host_ack", host_ack, e_ack);
        if (host_ack) ack_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_host();
        host_req = 1'b1;
        tick();
        host_req = 1'b0;
    endtask

    task automatic wait_start(input int budget, output int s);
        s = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rd_start) begin
                s = cyc;
                break;
            end
        end
        chk("start_seen", rd_start, 1);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (res_valid) break;
            tick();
        end
        chk("valid_seen", res_valid, 1);
    endtask

    task automatic read(input bit ok, input logic [15:0] d);
        rd_busy = 1'b1;
        repeat (10) tick();
        rd_done = 1'b1;
        rd_ok   = ok;
        rd_data = d;
        tick();
        rd_done = 1'b0;
        rd_ok   = 1'b0;
        rd_busy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s0, s1, s2, a1, a2, h, m;
        n_chk = 0; n_fail = 0; ack_cnt = 0;
        rst_n = 1'b0; auto_en = 1'b0; host_req = 1'b0;
        rd_busy = 1'b0; rd_done = 1'b0; rd_ok = 1'b0;
        rd_data = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stale", stale, 1);
        chk("rst_valid", res_valid, 0);
        #1;
        rst_n = 1'b1;

        // Power-up gap, then a good read.
        repeat (5) tick();
        pulse_host();
        wait_start(300, s0);
        chk("t1_start_edge", s0, 101);
        read(1'b1, 16'h1A2B);
        chk("t1_data", res_data, 16'h1A2B);
        chk("t1_err", res_err, 0);
        chk("t1_stale", stale, 0);
        repeat (3) tick();
        chk("t1_acks", ack_cnt, 1);

        // Two checksum failures, then success.
        pulse_host();
        wait_start(300, s0);
        read(1'b0, 16'h1111);
        wait_start(300, s1);
        read(1'b0, 16'h2222);
        wait_start(300, s2);
        read(1'b1, 16'h1520);
        chk("t2_space1", s1 - s0, 112);
        chk("t2_space2", s2 - s1, 112);
        chk("t2_data", res_data, 16'h1520);
        chk("t2_err", res_err, 0);
        chk("t2_errcnt", err_count, 2);
        repeat (3) tick();
        chk("t2_acks", ack_cnt, 2);

        // Three timeouts exhaust the retries.
        pulse_host();
        wait_start(300, s0);
        wait_start(300, s1);
        wait_start(300, s2);
        wait_valid(100);
        chk("t3_space1", s1 - s0, 152);
        chk("t3_space2", s2 - s1, 152);
        chk("t3_err", res_err, 1);
        chk("t3_data", res_data, 16'h1520);
        chk("t3_stale", stale, 1);
        chk("t3_errcnt", err_count, 5);
        repeat (3) tick();
        chk("t3_acks", ack_cnt, 3);

        // Backpressure with a request arriving during publish.
        res_ready = 1'b0;
        pulse_host();
        wait_start(300, s0);
        read(1'b1, 16'h2233);
        for (int i = 0; i < 20; i++) begin
            chk("t4_hold_valid", res_valid, 1);
            chk("t4_hold_data", res_data, 16'h2233);
            host_req = (i == 5);
            tick();
        end
        host_req = 1'b0;
        res_ready = 1'b1;
        tick();
        wait_start(300, s1);
        read(1'b1, 16'h0445);
        repeat (3) tick();
        chk("t4_acks", ack_cnt, 5);
        chk("t4_last", last_good, 16'h0445);

        // Auto sampling and merge of a host request into an auto sample.
        auto_en = 1'b1;
        wait_start(700, a1);
        read(1'b1, 16'h0A01);
        wait_start(700, a2);
        read(1'b1, 16'h0A02);
        chk("t5_period", a2 - a1, 500);
        repeat (380) tick();
        pulse_host();
        wait_start(50, h);
        read(1'b1, 16'h0B01);
        chk("t5_host_edge", h - a2, 393);
        repeat (90) tick();
        pulse_host();
        wait_start(200, m);
        read(1'b1, 16'h0C01);
        chk("t5_merge_edge", m - a2, 505);
        repeat (3) tick();
        auto_en = 1'b0;
        chk("t5_acks", ack_cnt, 7);
        repeat (600) tick();

        // Reset while waiting on the reader.
        pulse_host();
        wait_start(300, s0);
        rd_busy = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rd_start", rd_start, 0);
        chk("t6_valid", res_valid, 0);
        chk("t6_stale", stale, 1);
        chk("t6_errcnt", err_count, 0);
        chk("t6_last", last_good, 0);
        repeat (3) tick();
        rd_busy = 1'b0;
        rst_n = 1'b1;
        rd_done = 1'b1;
        rd_ok = 1'b1;
        rd_data = 16'hDEAD;
        host_req = 1'b1;
        tick();
        rd_done = 1'b0;
        rd_ok = 1'b0;
        host_req = 1'b0;
        chk("t6_late_done_valid", res_valid, 0);
        wait_start(300, s1);
        chk("t6_start_edge", s1, 101);
        read(1'b1, 16'h3344);
        repeat (3) tick();
        chk("t6_acks", ack_cnt, 8);
        chk("t6_last_new", last_good, 16'h3344);
        chk("t6_errcnt_new", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
